run_length_cleaner: RTL

//  Parametrised two-pass run-length denoiser for one binarised QR scan row (bit 0 = pixel 0; 0 = dark, 1 = light).

---
 rtl/run_clean_pkg.sv | 9 +
 rtl/run_tracker.sv | 57 +++++
 rtl/run_length_cleaner.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/run_clean_pkg.sv
// Shared types and pixel colour constants for the run-length cleaner.
package run_clean_pkg;

    typedef enum logic [1:0] {IDLE, PASS_DARK, PASS_LIGHT, DONE} clean_state_t;

    localparam logic DARK  = 1'b0;
    localparam logic LIGHT = 1'b1;

endpackage

// File: rtl/run_tracker.sv
// Tracks the current run of the target colour during a scan and flags runs
// that end short of the minimum length. Time-shared across both passes.
module run_tracker #(
    parameter int unsigned IDX_W = 9
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             active,
    input  logic             first,
    input  logic             last,
    input  logic             pixel,
    input  logic             next_pixel,
    input  logic             target,
    input  logic [IDX_W-1:0] idx,
    input  logic [IDX_W-1:0] min_len,
    output logic             run_end,
    output logic [IDX_W-1:0] run_start,
    output logic             run_short
);

    logic             in_run_q;
    logic [IDX_W-1:0] len_q;
    logic [IDX_W-1:0] start_q;
    logic [IDX_W-1:0] len_cur;
    logic             hit;
    logic             cont;

    always_comb begin
        hit  = active && (pixel == target);
        // A new pass always opens a fresh run at idx 0.
        cont = in_run_q && !first;
        if (cont) begin
            len_cur   = (len_q == '1) ? len_q : len_q + 1'b1;
            run_start = start_q;
        end else begin
            len_cur   = IDX_W'(1);
            run_start = idx;
        end
        run_end   = hit && (last || (next_pixel != target));
        run_short = run_end && (len_cur < min_len);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            in_run_q <= 1'b0;
            len_q    <= '0;
            start_q  <= '0;
        end else begin
            in_run_q <= hit;
            if (hit) begin
                len_q   <= len_cur;
                start_q <= run_start;
            end
        end
    end

endmodule

// File: rtl/run_length_cleaner.sv
// Two-pass run-length denoiser for one binarised scan row, one pixel per clock.
// Optional CLEAN_STATS_EN adds removed-run counters for each pass.
module run_length_cleaner
    import run_clean_pkg::*;
#(
    parameter int unsigned WIDTH     = 480,
    parameter int unsigned MIN_DARK  = 6,
    parameter int unsigned MIN_LIGHT = 3,
    parameter int unsigned IDX_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic             start_in,
    output logic             busy_out,
    output logic             data_valid_out,
    output logic [WIDTH-1:0] clean_pattern_out
`ifdef CLEAN_STATS_EN
    ,
    output logic [IDX_W-1:0] dark_removed_out,
    output logic [IDX_W-1:0] light_removed_out
`endif
);

    localparam logic [WIDTH-1:0] ONES = '1;

    clean_state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_inc;
    logic [WIDTH-1:0] row_q;
    logic [WIDTH-1:0] clean_q;
    logic             busy_q;
    logic             valid_q;

    logic             accept;
    logic             scanning;
    logic             finish;
    logic             target;
    logic [IDX_W-1:0] min_len;
    logic             first;
    logic             last;
    logic [WIDTH-1:0] cur_shift;
    logic [WIDTH-1:0] nxt_shift;
    logic [WIDTH-1:0] mask;
    logic             run_end;
    logic             run_short;
    logic [IDX_W-1:0] run_start;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (start_in) state_d = PASS_DARK;
            PASS_DARK:  if (last) state_d = PASS_LIGHT;
            PASS_LIGHT: if (last) state_d = DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        accept   = (state_q == IDLE) && start_in;
        scanning = (state_q == PASS_DARK) || (state_q == PASS_LIGHT);
        finish   = (state_q == DONE);
        target   = (state_q == PASS_LIGHT) ? LIGHT : DARK;
        min_len  = (state_q == PASS_LIGHT) ? IDX_W'(MIN_LIGHT) : IDX_W'(MIN_DARK);
    end

    always_comb begin
        idx_inc   = idx_q + 1'b1;
        first     = (idx_q == '0);
        last      = (idx_q == IDX_W'(WIDTH - 1));
        cur_shift = row_q >> idx_q;
        nxt_shift = row_q >> idx_inc;
        // Covers run_start..idx_q inclusive; only already-scanned pixels are touched.
        mask      = (ONES << run_start) & (ONES >> (IDX_W'(WIDTH - 1) - idx_q));
    end

    run_tracker #(
        .IDX_W (IDX_W)
    ) u_tracker (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .active     (scanning),
        .first      (first),
        .last       (last),
        .pixel      (cur_shift[0]),
        .next_pixel (nxt_shift[0]),
        .target     (target),
        .idx        (idx_q),
        .min_len    (min_len),
        .run_end    (run_end),
        .run_start  (run_start),
        .run_short  (run_short)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            idx_q   <= '0;
            row_q   <= '0;
            clean_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= finish;
            if (accept) begin
                row_q  <= pattern_in;
                idx_q  <= '0;
                busy_q <= 1'b1;
            end else if (scanning) begin
                if (run_short) begin
                    row_q <= (target == DARK) ? (row_q | mask) : (row_q & ~mask);
                end
                idx_q <= last ? '0 : idx_inc;
            end else if (finish) begin
                clean_q <= row_q;
                busy_q  <= 1'b0;
            end
        end
    end

    assign busy_out          = busy_q;
    assign data_valid_out    = valid_q;
    assign clean_pattern_out = clean_q;

`ifdef CLEAN_STATS_EN
    logic [IDX_W-1:0] dark_cnt_q;
    logic [IDX_W-1:0] light_cnt_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            dark_cnt_q  <= '0;
            light_cnt_q <= '0;
        end else if (accept) begin
            dark_cnt_q  <= '0;
            light_cnt_q <= '0;
        end else if (run_short) begin
            if (target == DARK) dark_cnt_q <= dark_cnt_q + 1'b1;
            else                light_cnt_q <= light_cnt_q + 1'b1;
        end
    end

    assign dark_removed_out  = dark_cnt_q;
    assign light_removed_out = light_cnt_q;
`else
    // Stats counters are not built in this configuration.
`endif

endmodule
